// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch program counter sequencer with relative/absolute
// targets, a stall input and a hardware call/return stack that flags
// overflow and underflow.
// Optional feature macro: PC_HALT_HOLD_EN. When it is defined, halt freezes
// the PC and raises a sticky 'halted' output until start. While halted is
// set, every input except start is ignored.
module pc_seq_unit #(
  parameter int          PC_W     = 8,
  parameter int          OFF_W    = 8,
  parameter int          STACK_D  = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             CLK,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             flag,
  input  logic             abs_tgt,
  input  logic [OFF_W-1:0] offset,
  input  logic             call,
  input  logic             ret,
`ifdef PC_HALT_HOLD_EN
  output logic             halted,
`endif
  output logic [PC_W-1:0]  PC,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  // The pointer counts 0..STACK_D. The array index needs at least one bit.
  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_en;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  target;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty;
  logic [PC_W-1:0]  stack_mem [STACK_D];
`ifdef PC_HALT_HOLD_EN
  logic             halted_q, halted_d;
`endif

  assign pc_inc = pc_q + PC_W'(1);
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign full   = (sp_q == SP_W'(STACK_D));
  assign empty  = (sp_q == '0);

  // Transfer target: the offset is zero-extended when absolute, otherwise it
  // is sign-extended and added to the PC. Wrap-around is silent.
  always_comb begin
    if (abs_tgt) begin
      target = PC_W'(offset);
    end else begin
      target = pc_q + PC_W'($signed(offset));
    end
  end

  // Next-state selection, in priority order: halt, stall, ret, call, jump/branch.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`ifdef PC_HALT_HOLD_EN
    halted_d = halted_q;
    if (halted_q) begin
      pc_d = pc_q;
    end else if (halt) begin
      halted_d = 1'b1;
    end else
`else
    if (halt) begin
      pc_d = PC_W'(RESET_PC);
    end else
`endif
    if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (!empty) begin
        pc_d = stack_mem[rd_idx];
        sp_d = sp_q - SP_W'(1);
      end else begin
        err_d = 1'b1;
        pc_d  = pc_inc;
      end
    end else if (call) begin
      if (!full) begin
        push_en = !start;
        pc_d    = target;
        sp_d    = sp_q + SP_W'(1);
      end else begin
        err_d = 1'b1;
        pc_d  = pc_inc;
      end
    end else if (jump || (branch && flag)) begin
      pc_d = target;
    end else begin
      pc_d = pc_inc;
    end
  end

  // Control state registers. start reloads the PC and empties the stack.
  always_ff @(posedge CLK) begin
    if (start) begin
      pc_q  <= PC_W'(RESET_PC);
      sp_q  <= '0;
      err_q <= 1'b0;
`ifdef PC_HALT_HOLD_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
`ifdef PC_HALT_HOLD_EN
      halted_q <= halted_d;
`endif
    end
  end

  // Return-address storage. Its contents do not need a reset.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

  assign PC          = pc_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;
`ifdef PC_HALT_HOLD_EN
  assign halted      = halted_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed testbench for pc_seq_unit using the default parameters
// (PC_W=8, OFF_W=8, STACK_D=4, RESET_PC=0).
module tb_pc_seq_unit;

  logic       CLK = 1'b0;
  logic       start, halt, stall, jump, branch, flag, abs_tgt, call, ret;
  logic [7:0] offset;
  logic [7:0] PC;
  logic       stack_full, stack_empty, stack_err;
`ifdef PC_HALT_HOLD_EN
  logic       halted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pc_seq_unit #(.PC_W(8), .OFF_W(8), .STACK_D(4), .RESET_PC(0)) dut (
    .CLK(CLK), .start(start), .halt(halt), .stall(stall), .jump(jump),
    .branch(branch), .flag(flag), .abs_tgt(abs_tgt), .offset(offset),
    .call(call), .ret(ret),
`ifdef PC_HALT_HOLD_EN
    .halted(halted),
`endif
    .PC(PC), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clr();
    start = 0; halt = 0; stall = 0; jump = 0; branch = 0; flag = 0;
    abs_tgt = 0; call = 0; ret = 0; offset = 8'd0;
  endtask

  // One clock with the current inputs, then sample 1 ns after the edge and clear.
  task automatic tick();
    @(posedge CLK);
    #1;
    clr();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_pc(input string tag, input int exp);
    chk(tag, int'(PC), exp);
  endtask

  task automatic do_jump(input logic a, input logic [7:0] off);
    jump = 1; abs_tgt = a; offset = off; tick();
  endtask

  task automatic do_call(input logic a, input logic [7:0] off);
    call = 1; abs_tgt = a; offset = off; tick();
  endtask

  task automatic do_ret();
    ret = 1; tick();
  endtask

  initial begin
    clr();
    start = 1;
    #1;
    tick();
    chk_pc("reset_pc", 0);
    chk("reset_empty", int'(stack_empty), 1);
    chk("reset_full", int'(stack_full), 0);
    chk("reset_err", int'(stack_err), 0);

    // Free-running increment.
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_pc("idle_inc", i);
    end
    chk("idle_empty", int'(stack_empty), 1);
    chk("idle_err", int'(stack_err), 0);

    // Branches and jumps.
    do_jump(1, 8'd10);           chk_pc("jump_abs10", 10);
    branch = 1; flag = 1; offset = 8'hFD; tick();
    chk_pc("br_taken", 7);
    branch = 1; flag = 0; offset = 8'hFD; tick();
    chk_pc("br_not_taken", 8);
    do_jump(1, 8'd200);          chk_pc("jump_abs200", 200);

    // Wrap-around and stall.
    do_jump(1, 8'd250);          chk_pc("jump_abs250", 250);
    do_jump(0, 8'd10);           chk_pc("jump_wrap", 4);
    for (int i = 0; i < 3; i++) begin
      stall = 1; jump = 1; abs_tgt = 1; offset = 8'd99; tick();
      chk_pc("stall_hold", 4);
    end
    do_jump(0, 8'hFF);           chk_pc("jump_minus1", 3);
    do_jump(0, 8'd0);            chk_pc("jump_self", 3);

    // Nested calls and returns.
    do_jump(1, 8'd20);           chk_pc("jump_abs20", 20);
    do_call(1, 8'd40);           chk_pc("call1", 40);
    chk("call1_empty", int'(stack_empty), 0);
    tick();                      chk_pc("call1_inc", 41);
    do_call(1, 8'd60);           chk_pc("call2", 60);
    do_ret();                    chk_pc("ret1", 42);
    do_ret();                    chk_pc("ret2", 21);
    chk("ret2_empty", int'(stack_empty), 1);
    chk("ret2_err", int'(stack_err), 0);

    // Overflow then underflow with STACK_D=4.
    do_jump(1, 8'd100);          chk_pc("jump_abs100", 100);
    do_call(0, 8'd10);           chk_pc("ov_call1", 110);
    do_call(0, 8'd10);           chk_pc("ov_call2", 120);
    do_call(0, 8'd10);           chk_pc("ov_call3", 130);
    chk("ov_full3", int'(stack_full), 0);
    do_call(0, 8'd10);           chk_pc("ov_call4", 140);
    chk("ov_full4", int'(stack_full), 1);
    chk("ov_err4", int'(stack_err), 0);
    do_call(0, 8'd10);           chk_pc("ov_call5", 141);
    chk("ov_err5", int'(stack_err), 1);
    chk("ov_full5", int'(stack_full), 1);
    do_ret();                    chk_pc("un_ret1", 131);
    chk("un_full1", int'(stack_full), 0);
    do_ret();                    chk_pc("un_ret2", 121);
    do_ret();                    chk_pc("un_ret3", 111);
    do_ret();                    chk_pc("un_ret4", 101);
    chk("un_empty4", int'(stack_empty), 1);
    do_ret();                    chk_pc("un_ret5", 102);
    chk("un_err5", int'(stack_err), 1);

    // ret wins over a simultaneous call.
    do_call(1, 8'd50);           chk_pc("cr_call", 50);
    call = 1; ret = 1; abs_tgt = 1; offset = 8'd77; tick();
    chk_pc("cr_ret_wins", 103);
    chk("cr_empty", int'(stack_empty), 1);

    // Reset with a partly filled stack.
    do_call(1, 8'd60);           chk_pc("rs_call1", 60);
    do_call(1, 8'd70);           chk_pc("rs_call2", 70);
    start = 1; call = 1; offset = 8'd5; abs_tgt = 1; tick();
    chk_pc("rs_pc", 0);
    chk("rs_empty", int'(stack_empty), 1);
    chk("rs_full", int'(stack_full), 0);
    chk("rs_err", int'(stack_err), 0);

    // Halt behaviour.
    do_jump(1, 8'd33);           chk_pc("h_jump33", 33);
`ifdef PC_HALT_HOLD_EN
    chk("h_halted0", int'(halted), 0);
    halt = 1; tick();
    chk_pc("h_hold", 33);
    chk("h_halted1", int'(halted), 1);
    do_jump(1, 8'd90);           chk_pc("h_ign_jump", 33);
    do_ret();                    chk_pc("h_ign_ret", 33);
    chk("h_ign_err", int'(stack_err), 0);
    chk("h_halted2", int'(halted), 1);
    start = 1; tick();
    chk_pc("h_start", 0);
    chk("h_halted3", int'(halted), 0);
`else
    do_call(1, 8'd90);           chk_pc("h_call", 90);
    halt = 1; stall = 1; tick();
    chk_pc("h_reset_pc", 0);
    chk("h_empty", int'(stack_empty), 0);
    chk("h_err", int'(stack_err), 0);
    do_ret();                    chk_pc("h_ret", 34);
    chk("h_ret_empty", int'(stack_empty), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
